// File: rtl/uart_pkg.sv
// Shared UART constants and helpers used by the shift datapath and its counter.
package uart_pkg;

  localparam int unsigned UART_FRAME_W = 10;
  localparam logic [31:0] IDLE_MARK    = '1;

  function automatic int unsigned CNT_W(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/shift_bit_counter.sv
// Counts shifts within a frame; wraps at WIDTH-1 and raises a one-cycle DONE.
module shift_bit_counter
  import uart_pkg::*;
#(
  parameter int unsigned WIDTH = UART_FRAME_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       load,
  input  logic                       shift,
  output logic [CNT_W(WIDTH)-1:0]    cnt,
  output logic                       done
);

  localparam int unsigned   CW   = CNT_W(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [CW-1:0] cnt_d, cnt_q;
  logic          done_d, done_q;

  always_comb begin
    cnt_d  = cnt_q;
    done_d = 1'b0;
    if (clr || load) begin
      cnt_d = '0;
    end else if (shift) begin
      if (cnt_q == LAST) begin
        cnt_d  = '0;
        done_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign cnt  = cnt_q;
  assign done = done_q;

endmodule

// File: rtl/shift_register_param.sv
// Parametrised UART shift register: serial-in/parallel-load, direction fixed at elaboration.
module shift_register_param
  import uart_pkg::*;
#(
  parameter int unsigned      WIDTH     = UART_FRAME_W,
  parameter bit               LSB_FIRST = 1'b1,
  parameter logic [WIDTH-1:0] RST_VAL   = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    CLR,
  input  logic                    LOAD,
  input  logic [WIDTH-1:0]        D,
  input  logic                    SHIFT,
  input  logic                    SDI,
  output logic                    SDO,
  output logic [WIDTH-1:0]        Q,
  output logic [CNT_W(WIDTH)-1:0] CNT,
  output logic                    DONE
);

  logic [WIDTH-1:0] q_d, q_q;
  logic [WIDTH-1:0] q_shift;

  if (LSB_FIRST) begin : g_lsb_first
    assign q_shift = {SDI, q_q[WIDTH-1:1]};
    assign SDO     = q_q[0];
  end else begin : g_msb_first
    assign q_shift = {q_q[WIDTH-2:0], SDI};
    assign SDO     = q_q[WIDTH-1];
  end

  always_comb begin
    q_d = q_q;
    if (CLR) begin
      q_d = RST_VAL;
    end else if (LOAD) begin
      q_d = D;
    end else if (SHIFT) begin
      q_d = q_shift;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= RST_VAL;
    end else begin
      q_q <= q_d;
    end
  end

  assign Q = q_q;

  shift_bit_counter #(
    .WIDTH(WIDTH)
  ) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (CLR),
    .load (LOAD),
    .shift(SHIFT),
    .cnt  (CNT),
    .done (DONE)
  );

endmodule

// File: tb/tb_shift_register_param.sv
// Bench for shift_register_param: RX, TX and MSB-first instances share clock and reset.
module tb_shift_register_param;
  import uart_pkg::*;

  logic clk;
  logic rst;

  logic       clr_a, ld_a, sh_a, sdi_a, sdo_a, done_a;
  logic [9:0] d_a, q_a;
  logic [CNT_W(10)-1:0] cnt_a;

  logic       clr_b, ld_b, sh_b, sdi_b, sdo_b, done_b;
  logic [9:0] d_b, q_b;
  logic [CNT_W(10)-1:0] cnt_b;

  logic       clr_c, ld_c, sh_c, sdi_c, sdo_c, done_c;
  logic [7:0] d_c, q_c;
  logic [CNT_W(8)-1:0] cnt_c;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_a[$];
  logic [31:0] exp_b[$];
  logic [31:0] exp_c[$];

  shift_register_param #(.WIDTH(10), .LSB_FIRST(1'b1), .RST_VAL(10'h000)) dut_a (
    .clk(clk), .rst(rst), .CLR(clr_a), .LOAD(ld_a), .D(d_a), .SHIFT(sh_a), .SDI(sdi_a),
    .SDO(sdo_a), .Q(q_a), .CNT(cnt_a), .DONE(done_a));

  shift_register_param #(.WIDTH(10), .LSB_FIRST(1'b1), .RST_VAL(IDLE_MARK[9:0])) dut_b (
    .clk(clk), .rst(rst), .CLR(clr_b), .LOAD(ld_b), .D(d_b), .SHIFT(sh_b), .SDI(sdi_b),
    .SDO(sdo_b), .Q(q_b), .CNT(cnt_b), .DONE(done_b));

  shift_register_param #(.WIDTH(8), .LSB_FIRST(1'b0), .RST_VAL(8'h00)) dut_c (
    .clk(clk), .rst(rst), .CLR(clr_c), .LOAD(ld_c), .D(d_c), .SHIFT(sh_c), .SDI(sdi_c),
    .SDO(sdo_c), .Q(q_c), .CNT(cnt_c), .DONE(done_c));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, required finish before 200000");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitors: every DONE must consume one expected frame
  always @(negedge clk) begin
    if (!rst && done_a) begin
      check("done_a_expected", 32'(exp_a.size() != 0), 32'd1);
      if (exp_a.size() != 0) check("frame_a", 32'(q_a), exp_a.pop_front());
    end
  end

  always @(negedge clk) begin
    if (!rst && done_b) begin
      check("done_b_expected", 32'(exp_b.size() != 0), 32'd1);
      if (exp_b.size() != 0) check("frame_b", 32'(q_b), exp_b.pop_front());
    end
  end

  always @(negedge clk) begin
    if (!rst && done_c) begin
      check("done_c_expected", 32'(exp_c.size() != 0), 32'd1);
      if (exp_c.size() != 0) check("frame_c", 32'(q_c), exp_c.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic shift_a(input logic b);
    sh_a = 1'b1; sdi_a = b; tick(); sh_a = 1'b0;
  endtask

  task automatic shift_b(input logic b);
    sh_b = 1'b1; sdi_b = b; tick(); sh_b = 1'b0;
  endtask

  task automatic shift_c(input logic b);
    sh_c = 1'b1; sdi_c = b; tick(); sh_c = 1'b0;
  endtask

  logic rx_bits  [10] = '{0, 1, 0, 1, 1, 0, 0, 1, 0, 1};
  logic tx_sdo   [10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
  logic c_bits   [8]  = '{1, 0, 1, 0, 0, 1, 0, 1};
  logic c_sdo    [8]  = '{0, 0, 1, 1, 1, 1, 0, 0};

  initial begin
    rst = 1'b1;
    {clr_a, ld_a, sh_a, sdi_a} = '0; d_a = '0;
    {clr_b, ld_b, sh_b, sdi_b} = '0; d_b = '0;
    {clr_c, ld_c, sh_c, sdi_c} = '0; d_c = '0;
    tick();
    tick();
    check("por_q_a", 32'(q_a), 32'h000);
    check("por_q_b", 32'(q_b), 32'h3FF);
    check("por_cnt_a", 32'(cnt_a), 32'd0);
    check("por_done_a", 32'(done_a), 32'd0);
    rst = 1'b0;
    tick();

    // RX frame, default parameters
    exp_a.push_back(32'h29A);
    for (int unsigned i = 0; i < 10; i++) begin
      shift_a(rx_bits[i]);
      if (i < 9) check("rx_cnt", 32'(cnt_a), 32'(i + 1));
    end
    check("rx_q", 32'(q_a), 32'h29A);
    check("rx_cnt_wrap", 32'(cnt_a), 32'd0);
    check("rx_done", 32'(done_a), 32'd1);
    tick();
    check("rx_done_one_cycle", 32'(done_a), 32'd0);

    // Priority: LOAD beats SHIFT
    for (int unsigned i = 0; i < 3; i++) shift_a(1'b0);
    ld_a = 1'b1; d_a = 10'h2B5; sh_a = 1'b1; sdi_a = 1'b1;
    tick();
    ld_a = 1'b0; sh_a = 1'b0;
    check("ld_sh_q", 32'(q_a), 32'h2B5);
    check("ld_sh_cnt", 32'(cnt_a), 32'd0);

    // CLR after 7 shifts, then a full fresh frame
    for (int unsigned i = 0; i < 7; i++) shift_a(1'b0);
    check("pre_clr_cnt", 32'(cnt_a), 32'd7);
    clr_a = 1'b1; tick(); clr_a = 1'b0;
    check("clr_cnt", 32'(cnt_a), 32'd0);
    check("clr_q", 32'(q_a), 32'h000);
    exp_a.push_back(32'h3FF);
    for (int unsigned i = 0; i < 10; i++) begin
      shift_a(1'b1);
      if (i < 9) check("clr_no_early_done", 32'(done_a), 32'd0);
    end
    check("clr_frame_done", 32'(done_a), 32'd1);

    // Priority on the idle-mark instance: CLR beats LOAD
    ld_b = 1'b1; d_b = 10'h155; tick(); ld_b = 1'b0;
    check("b_load_q", 32'(q_b), 32'h155);
    clr_b = 1'b1; ld_b = 1'b1; d_b = 10'h0AA; tick(); clr_b = 1'b0; ld_b = 1'b0;
    check("clr_ld_q", 32'(q_b), 32'h3FF);
    check("clr_ld_cnt", 32'(cnt_b), 32'd0);

    // TX frame out of the idle-mark instance
    ld_b = 1'b1; d_b = 10'b1_1010_0101_0; tick(); ld_b = 1'b0;
    exp_b.push_back(32'h3FF);
    for (int unsigned i = 0; i < 10; i++) begin
      check("tx_sdo", 32'(sdo_b), 32'(tx_sdo[i]));
      shift_b(1'b1);
    end
    check("tx_q", 32'(q_b), 32'h3FF);
    check("tx_done", 32'(done_b), 32'd1);

    // Back-to-back frames with SHIFT held
    clr_a = 1'b1; tick(); clr_a = 1'b0;
    exp_a.push_back(32'h3FF);
    exp_a.push_back(32'h000);
    sh_a = 1'b1;
    for (int unsigned k = 1; k <= 20; k++) begin
      sdi_a = (k <= 10);
      tick();
      check("b2b_cnt", 32'(cnt_a), 32'(k % 10));
      check("b2b_done", 32'(done_a), 32'(k % 10 == 0));
    end
    sh_a = 1'b0;

    // MSB-first, WIDTH=8
    ld_c = 1'b1; d_c = 8'h3C; tick(); ld_c = 1'b0;
    check("c_load_q", 32'(q_c), 32'h3C);
    exp_c.push_back(32'hA5);
    for (int unsigned i = 0; i < 8; i++) begin
      check("c_sdo", 32'(sdo_c), 32'(c_sdo[i]));
      shift_c(c_bits[i]);
    end
    check("c_q", 32'(q_c), 32'hA5);
    check("c_cnt", 32'(cnt_c), 32'd0);
    check("c_done", 32'(done_c), 32'd1);
    tick();
    check("c_done_one_cycle", 32'(done_c), 32'd0);

    // Asynchronous reset mid-frame, between clock edges
    for (int unsigned i = 0; i < 4; i++) shift_a(1'b1);
    for (int unsigned i = 0; i < 4; i++) shift_b(1'b0);
    for (int unsigned i = 0; i < 3; i++) shift_c(1'b1);
    check("pre_rst_q_a", 32'(q_a), 32'h3C0);
    check("pre_rst_q_b", 32'(q_b), 32'h03F);
    check("pre_rst_q_c", 32'(q_c), 32'h2F);
    #2 rst = 1'b1;
    #1;
    check("arst_q_a", 32'(q_a), 32'h000);
    check("arst_cnt_a", 32'(cnt_a), 32'd0);
    check("arst_done_a", 32'(done_a), 32'd0);
    check("arst_sdo_a", 32'(sdo_a), 32'd0);
    check("arst_q_b", 32'(q_b), 32'h3FF);
    check("arst_sdo_b", 32'(sdo_b), 32'd1);
    check("arst_cnt_b", 32'(cnt_b), 32'd0);
    check("arst_q_c", 32'(q_c), 32'h00);
    check("arst_cnt_c", 32'(cnt_c), 32'd0);
    check("arst_sdo_c", 32'(sdo_c), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("post_rst_cnt_a", 32'(cnt_a), 32'd0);
    check("post_rst_done_a", 32'(done_a), 32'd0);

    check("pending_a", 32'(exp_a.size()), 32'd0);
    check("pending_b", 32'(exp_b.size()), 32'd0);
    check("pending_c", 32'(exp_c.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
